cdc_bus_arbiter: RTL and testbench

- Source-domain controller for the DATA_SYNC bus synchronizer.
- Arbitrates round-robin among NUM_REQ requesters and latches the winner's word onto unsync_bus.
- Drives bus_enable high for a fixed hold window, then low for a fixed gap, so every destination-side enable_pulse samples a stable bus.
- Sits between source-clock producers (e.g. register file, ALU result) and the DATA_SYNC instance feeding the other clock domain.

---
 rtl/cdc_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_cdc_bus_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cdc_bus_arbiter.sv
// Source-domain front end for a DATA_SYNC bus synchronizer: round-robin picks one
// requester, holds its word with bus_enable high for HOLD_CYCLES, then idles the enable for a GAP.
module cdc_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic                         busy
);

    localparam int MAX_WIN = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_WIN) < 1) ? 1 : $clog2(MAX_WIN);
    localparam int PTR_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    // The windows must outlast the downstream synchronizer depth or the far side can miss the enable.
    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < NUM_STAGES + 1 || GAP_CYCLES < NUM_STAGES) begin : g_param_check
        $error("cdc_bus_arbiter: illegal parameter combination");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   en_q, en_d;
    logic [PTR_W-1:0]       idx_s;
    logic [PTR_W-1:0]       win_s;
    logic                   found_s;

    // Round-robin search: first asserted request at or after ptr, wrapping around.
    always_comb begin
        idx_s   = ptr_q;
        win_s   = ptr_q;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                win_s   = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/HOLD/GAP sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        bus_d   = bus_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d        = HOLD;
                    bus_d          = data_in[int'(win_s)*BUS_WIDTH +: BUS_WIDTH];
                    en_d           = 1'b1;
                    grant_d[win_s] = 1'b1;
                    cnt_d          = CNT_W'(HOLD_CYCLES - 1);
                    ptr_d          = PTR_W'((int'(win_s) + 1) % NUM_REQ);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
        end
    end

    assign grant      = grant_q;
    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// Directed bench for cdc_bus_arbiter: per-cycle vector table plus fairness and
// back-to-back sequences, all with hand-computed expectations.
module tb_cdc_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req;
    logic [15:0] data_in;
    logic [1:0]  grant;
    logic [7:0]  unsync_bus;
    logic        bus_enable;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    cdc_bus_arbiter #(
        .NUM_REQ(2), .BUS_WIDTH(8), .NUM_STAGES(2), .HOLD_CYCLES(3), .GAP_CYCLES(3)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .data_in(data_in), .grant(grant),
        .unsync_bus(unsync_bus), .bus_enable(bus_enable), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] exp_grant;
        logic [7:0] exp_bus;
        logic       exp_en;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] q, input logic [1:0] g,
                                input logic [7:0] b, input logic e, input logic y);
        vec_t v;
        v.rst_n = r; v.req = q; v.exp_grant = g; v.exp_bus = b; v.exp_en = e; v.exp_busy = y;
        return v;
    endfunction

    task automatic step_check(input string name, input int idx, input logic [1:0] eg,
                              input logic [7:0] eb, input logic ee, input logic ey);
        logic [11:0] act;
        logic [11:0] exp;
        @(posedge CLK);
        #1;
        act = {grant, unsync_bus, bus_enable, busy};
        exp = {eg, eb, ee, ey};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got grant=%b bus=%h en=%b busy=%b, want grant=%b bus=%h en=%b busy=%b",
                     name, idx, act[11:10], act[9:2], act[1], act[0], eg, eb, ee, ey);
        end
    endtask

    initial begin
        data_in = 16'hC0C1;
        RST     = 1'b0;
        req     = 2'b11;

        // reset held with both requesting
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 8'h00, 1'b0, 1'b0));
        // single transfer from requester 0
        vecs.push_back(mk(1'b1, 2'b01, 2'b01, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b0));
        // requester 1 drops its request during HOLD
        vecs.push_back(mk(1'b1, 2'b10, 2'b10, 8'hC0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b10, 2'b00, 8'hC0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC0, 1'b0, 1'b0));
        // reset in the second HOLD cycle clears ptr, so requester 0 wins next
        vecs.push_back(mk(1'b1, 2'b01, 2'b01, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b11, 2'b00, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b11, 2'b01, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'hC1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            RST = vecs[i].rst_n;
            req = vecs[i].req;
            step_check("table", i, vecs[i].exp_grant, vecs[i].exp_bus, vecs[i].exp_en, vecs[i].exp_busy);
        end

        // fairness: both held, grants alternate 01,10,01,10 every 7 cycles
        RST = 1'b1;
        req = 2'b11;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 7; c++) begin
                step_check("fair", p*7 + c,
                           (c == 0) ? ((p % 2 == 1) ? 2'b10 : 2'b01) : 2'b00,
                           (p % 2 == 1) ? 8'hC0 : 8'hC1,
                           (c < 3) ? 1'b1 : 1'b0,
                           (c < 6) ? 1'b1 : 1'b0);
                if (p == 3 && c == 0) req = 2'b00;
            end
        end

        // back-to-back single requester: 3 high / 4 low, word stays 0xC1
        data_in = 16'hC0C1;
        req     = 2'b01;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 7; c++) begin
                step_check("b2b", p*7 + c,
                           (c == 0) ? 2'b01 : 2'b00,
                           8'hC1,
                           (c < 3) ? 1'b1 : 1'b0,
                           (c < 6) ? 1'b1 : 1'b0);
                if (p == 2 && c == 0) req = 2'b00;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
